// File: rtl/game_pkg.sv
// Shared game-session definitions: FSM state encoding and the display ceilings
// that both this counter and the score/time display driver use.
package game_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRun   = 2'd1,
      StPause = 2'd2,
      StDone  = 2'd3
   } game_state_e;

   localparam int unsigned DefaultTimeMax  = 9999;
   localparam int unsigned DefaultScoreMax = 999;

   // Internal datapath widths; upper output bits are tied to zero.
   localparam int unsigned ScoreW = 11;
   localparam int unsigned TimeW  = 14;

endpackage

// File: rtl/tick_gen.sv
// Seconds prescaler: counts enabled cycles and pulses tick on the last cycle of
// each CLK_HZ period. Holds its count while disabled so a pause loses no time.
module tick_gen #(
   parameter int unsigned CLK_HZ = 100_000_000
) (
   input  logic clock,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int unsigned CntW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(CLK_HZ - 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   assign tick = en && (cnt_q == CntLast);

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/game_stat_counter.sv
// Game-session FSM with elapsed-seconds and saturating score counters feeding
// the display driver. Define BONUS_STREAK_EN to double points for quick hit streaks.
module game_stat_counter
   import game_pkg::*;
#(
   parameter int unsigned CLK_HZ     = 100_000_000,
   parameter int unsigned TIME_MAX   = DefaultTimeMax,
   parameter int unsigned SCORE_MAX  = DefaultScoreMax,
   parameter int unsigned STREAK_CYC = 50_000_000
) (
   input  logic        clock,
   input  logic        rst,
   input  logic        start,
   input  logic        pause,
   input  logic        hit,
   input  logic [3:0]  hit_pts,
   input  logic        game_over,
   output logic [31:0] score,
   output logic [31:0] total_time,
   output logic        running,
   output logic        done
);

   if (CLK_HZ < 2 || STREAK_CYC < 1 || SCORE_MAX > 2000 || TIME_MAX >= 2 ** TimeW)
   begin : g_param_check
      $error("game_stat_counter: parameter out of range");
   end

   game_state_e state_q, state_d;
   logic [ScoreW-1:0] score_q, score_d, pts_eff, score_sum;
   logic [TimeW-1:0]  time_q, time_d, time_inc;
   logic running_q, running_d, done_q, done_d;
   logic tick, hit_ok, at_ceiling;

   tick_gen #(
      .CLK_HZ (CLK_HZ)
   ) u_tick_gen (
      .clock (clock),
      .rst   (rst),
      .en    (state_q == StRun),
      .clr   (start),
      .tick  (tick)
   );

   assign hit_ok     = hit && (state_q == StRun || state_q == StPause);
   assign time_inc   = time_q + 1'b1;
   assign at_ceiling = tick && (time_inc >= TimeW'(TIME_MAX));

`ifdef BONUS_STREAK_EN
   localparam int unsigned StreakW = $clog2(STREAK_CYC + 1);

   // Cycles left in the current streak window; zero means no streak.
   logic [StreakW-1:0] streak_q, streak_d;

   always_comb begin
      streak_d = streak_q;
      if (start) begin
         streak_d = '0;
      end else if (hit_ok) begin
         streak_d = StreakW'(STREAK_CYC);
      end else if (state_q == StRun && streak_q != '0) begin
         streak_d = streak_q - 1'b1;
      end
   end

   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         streak_q <= '0;
      end else begin
         streak_q <= streak_d;
      end
   end

   assign pts_eff = (streak_q != '0) ? ScoreW'({hit_pts, 1'b0}) : ScoreW'(hit_pts);
`else
   assign pts_eff = ScoreW'(hit_pts);
`endif

   assign score_sum = score_q + pts_eff;

   always_comb begin
      state_d = state_q;
      if (start) begin
         state_d = StRun;
      end else begin
         case (state_q)
            StRun: begin
               if (game_over || at_ceiling) state_d = StDone;
               else if (pause)              state_d = StPause;
            end
            StPause: begin
               if (game_over)   state_d = StDone;
               else if (!pause) state_d = StRun;
            end
            default: state_d = state_q;
         endcase
      end
   end

   always_comb begin
      running_d = (state_d == StRun);
      done_d    = (state_d == StDone);
   end

   always_comb begin
      score_d = score_q;
      time_d  = time_q;
      if (start) begin
         score_d = '0;
         time_d  = '0;
      end else begin
         if (hit_ok) begin
            score_d = (score_sum > ScoreW'(SCORE_MAX)) ? ScoreW'(SCORE_MAX) : score_sum;
         end
         if (tick && time_q < TimeW'(TIME_MAX)) begin
            time_d = time_inc;
         end
      end
   end

   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         state_q   <= StIdle;
         score_q   <= '0;
         time_q    <= '0;
         running_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         score_q   <= score_d;
         time_q    <= time_d;
         running_q <= running_d;
         done_q    <= done_d;
      end
   end

   assign score      = {{(32 - ScoreW){1'b0}}, score_q};
   assign total_time = {{(32 - TimeW){1'b0}}, time_q};
   assign running    = running_q;
   assign done       = done_q;

endmodule

// File: tb/tb_game_stat_counter.sv
// Directed bench for game_stat_counter with a 10-cycle second and 5-cycle streak
// window; a second instance with a 3 s ceiling covers the time limit.
module tb_game_stat_counter;

   logic        clock = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0, pause = 1'b0, hit = 1'b0, game_over = 1'b0;
   logic [3:0]  hit_pts = 4'd0;
   logic [31:0] score, total_time, t_score, t_time;
   logic        running, done, t_running, t_done;

   int total = 0;
   int bad = 0;

   always #5 clock = ~clock;

   game_stat_counter #(
      .CLK_HZ     (10),
      .STREAK_CYC (5)
   ) u_dut (
      .clock      (clock),
      .rst        (rst),
      .start      (start),
      .pause      (pause),
      .hit        (hit),
      .hit_pts    (hit_pts),
      .game_over  (game_over),
      .score      (score),
      .total_time (total_time),
      .running    (running),
      .done       (done)
   );

   game_stat_counter #(
      .CLK_HZ     (10),
      .TIME_MAX   (3),
      .STREAK_CYC (5)
   ) u_dut_t (
      .clock      (clock),
      .rst        (rst),
      .start      (start),
      .pause      (pause),
      .hit        (hit),
      .hit_pts    (hit_pts),
      .game_over  (game_over),
      .score      (t_score),
      .total_time (t_time),
      .running    (t_running),
      .done       (t_done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic do_hit(input logic [3:0] p);
      hit = 1'b1;
      hit_pts = p;
      @(negedge clock);
      hit = 1'b0;
   endtask

   initial begin
      // Reset state
      cycles(2);
      chk("rst_score", score, 0);
      chk("rst_time", total_time, 0);
      chk("rst_running", {31'd0, running}, 0);
      chk("rst_done", {31'd0, done}, 0);
      rst = 1'b1;

      // IDLE: hits ignored, no time counted
      do_hit(4'd5);
      cycles(15);
      chk("idle_score", score, 0);
      chk("idle_time", total_time, 0);
      chk("idle_running", {31'd0, running}, 0);

      // Plain run: seconds roll over every 10 cycles
      pulse_start();
      chk("run_running", {31'd0, running}, 1);
      chk("run_done", {31'd0, done}, 0);
      cycles(9);
      chk("run_time_9cyc", total_time, 0);
      cycles(1);
      chk("run_time_10cyc", total_time, 1);
      cycles(25);
      chk("run_time_35cyc", total_time, 3);
      chk("run_running_35", {31'd0, running}, 1);

      // Hit latency, then hit together with game_over
      do_hit(4'd7);
      chk("hit_latency", score, 7);
      cycles(6);
      hit = 1'b1;
      hit_pts = 4'd2;
      game_over = 1'b1;
      @(negedge clock);
      hit = 1'b0;
      game_over = 1'b0;
      chk("over_score", score, 9);
      chk("over_done", {31'd0, done}, 1);
      chk("over_running", {31'd0, running}, 0);
      chk("over_time", total_time, 4);
      cycles(15);
      do_hit(4'd4);
      chk("done_hit_ignored", score, 9);
      chk("done_time_frozen", total_time, 4);

      // Restart from DONE, then asynchronous reset mid-run
      pulse_start();
      chk("restart_running", {31'd0, running}, 1);
      chk("restart_score", score, 0);
      chk("restart_time", total_time, 0);
      do_hit(4'd4);
      cycles(11);
      chk("pre_rst_score", score, 4);
      chk("pre_rst_time", total_time, 1);
      #2 rst = 1'b0;
      #1;
      chk("async_score", score, 0);
      chk("async_time", total_time, 0);
      chk("async_running", {31'd0, running}, 0);
      chk("async_done", {31'd0, done}, 0);
      @(negedge clock);
      rst = 1'b1;
      cycles(15);
      chk("post_rst_idle_time", total_time, 0);
      chk("post_rst_idle_run", {31'd0, running}, 0);

      // Pause freezes time but still accepts hits
      pulse_start();
      pause = 1'b1;
      cycles(5);
      chk("pause_running", {31'd0, running}, 0);
      do_hit(4'd5);
      chk("pause_hit", score, 5);
      cycles(14);
      pause = 1'b0;
      cycles(9);
      chk("pause_time_9", total_time, 0);
      cycles(1);
      chk("pause_time_10", total_time, 1);
      chk("pause_running_after", {31'd0, running}, 1);

      // Score saturation: hits spaced beyond the streak window
      pulse_start();
      for (int i = 0; i < 67; i++) begin
         do_hit((i == 66) ? 4'd5 : 4'd15);
         cycles(6);
      end
      chk("score_995", score, 995);
      do_hit(4'd9);
      chk("score_sat", score, 999);
      cycles(6);
      do_hit(4'd1);
      chk("score_sat_hold", score, 999);

      // Streak window: second hit 3, 5 and 8 cycles after the first
      pulse_start();
      do_hit(4'd3);
      cycles(2);
      do_hit(4'd3);
`ifdef BONUS_STREAK_EN
      chk("streak_gap3", score, 9);
`else
      chk("streak_gap3", score, 6);
`endif
      pulse_start();
      do_hit(4'd3);
      cycles(4);
      do_hit(4'd3);
`ifdef BONUS_STREAK_EN
      chk("streak_gap5", score, 9);
`else
      chk("streak_gap5", score, 6);
`endif
      pulse_start();
      do_hit(4'd3);
      cycles(7);
      do_hit(4'd3);
      chk("streak_gap8", score, 6);

      // start outranks game_over
      start = 1'b1;
      game_over = 1'b1;
      @(negedge clock);
      start = 1'b0;
      game_over = 1'b0;
      chk("start_wins_run", {31'd0, running}, 1);
      chk("start_wins_done", {31'd0, done}, 0);
      chk("start_wins_score", score, 0);

      // Time ceiling on the TIME_MAX=3 instance
      pulse_start();
      cycles(29);
      chk("ceil_time_29", t_time, 2);
      chk("ceil_running_29", {31'd0, t_running}, 1);
      cycles(1);
      chk("ceil_time_30", t_time, 3);
      chk("ceil_done", {31'd0, t_done}, 1);
      chk("ceil_running", {31'd0, t_running}, 0);
      cycles(10);
      chk("ceil_no_wrap", t_time, 3);
      pulse_start();
      chk("ceil_restart_time", t_time, 0);
      chk("ceil_restart_run", {31'd0, t_running}, 1);
      chk("ceil_restart_done", {31'd0, t_done}, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
